// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined parallel-prefix adder.
// Holds the generate/propagate pair, default parameters and legality checks.
package adder_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_GROUP  = 4;
    localparam int DEF_STAGES = 2;
    localparam int DEF_TAG_W  = 4;

    function automatic bit stagesLegal(int stages);
        return (stages >= 1) && (stages <= 3);
    endfunction

    function automatic bit shapeLegal(int width, int group);
        int ng;
        if (width < 4 || width > 64 || (width & (width - 1)) != 0) return 1'b0;
        if (group < 1 || (width % group) != 0) return 1'b0;
        ng = width / group;
        return (ng >= 2) && ((ng & (ng - 1)) == 0);
    endfunction

    // hi is the more significant span; lo is the adjacent less significant span
    function automatic gp_t gpCombine(gp_t hi, gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/prefix_tree_gp.sv
// Recursive Sklansky prefix tree over group generate/propagate pairs.
// A register row is placed after level CUT_LEVEL (0 = on the inputs); negative means none.
module prefix_tree_gp
    import adder_pkg::*;
#(
    parameter int N         = 8,
    parameter int CUT_LEVEL = -1
) (
    input  logic        clk,
    input  logic        i_en,
    input  gp_t [N-1:0] i_gp,
    output gp_t [N-1:0] o_gp
);

    localparam int DEPTH = $clog2(N);

    gp_t [N-1:0] w_level;

    if (N == 1) begin : g_leaf
        assign w_level = i_gp;
    end else begin : g_node
        localparam int HALF = N / 2;

        gp_t [HALF-1:0] w_lo;
        gp_t [HALF-1:0] w_hi;

        prefix_tree_gp #(.N(HALF), .CUT_LEVEL(CUT_LEVEL)) u_lo (
            .clk  (clk),
            .i_en (i_en),
            .i_gp (i_gp[HALF-1:0]),
            .o_gp (w_lo)
        );

        prefix_tree_gp #(.N(HALF), .CUT_LEVEL(CUT_LEVEL)) u_hi (
            .clk  (clk),
            .i_en (i_en),
            .i_gp (i_gp[N-1:HALF]),
            .o_gp (w_hi)
        );

        // Every upper-half prefix absorbs the full lower-half span
        always_comb begin
            w_level[HALF-1:0] = w_lo;
            for (int i = 0; i < HALF; i++) begin
                w_level[HALF+i] = gpCombine(w_hi[i], w_lo[HALF-1]);
            end
        end
    end

    if (CUT_LEVEL == DEPTH) begin : g_cut
        gp_t [N-1:0] r_gp;

        always_ff @(posedge clk) begin
            if (i_en) r_gp <= w_level;
        end

        assign o_gp = r_gp;
    end else begin : g_comb
        logic w_unusedCtl;
        assign w_unusedCtl = clk ^ i_en;
        assign o_gp        = w_level;
    end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Elastic pipelined adder/subtractor: group g/p, prefix tree over groups, intra-group ripple.
// STAGES selects where register rows sit; each row carries a valid bit and stalls on backpressure.
module pipelined_prefix_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int GROUP  = DEF_GROUP,
    parameter int STAGES = DEF_STAGES,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NG     = WIDTH / GROUP;
    localparam int LEVELS = $clog2(NG);
    localparam int CUT    = (STAGES == 1) ? -1 : (STAGES == 2) ? LEVELS / 2 : 0;

    if (!stagesLegal(STAGES) || !shapeLegal(WIDTH, GROUP)) begin : g_badParams
        $error("pipelined_prefix_adder: illegal WIDTH/GROUP/STAGES combination");
    end

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] w_adv;
    logic [STAGES:0]   w_validChain;

    // A stage moves when any stage from it to the output has a hole, or the consumer takes
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_adv[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!r_valid[j]) w_adv[k] = 1'b1;
            end
        end
    end

    assign w_validChain = {r_valid, in_valid};
    assign in_ready     = w_adv[0] && !rst;
    assign out_valid    = r_valid[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_adv[k]) r_valid[k] <= w_validChain[k];
            end
        end
    end

    logic [WIDTH-1:0] w_bEff;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic             w_c0;
    gp_t [NG-1:0]     w_grp;
    gp_t [NG-1:0]     w_pre;

    assign w_bEff = sub ? ~b : b;
    assign w_c0   = sub | cin;
    assign w_p    = a ^ w_bEff;
    assign w_g    = a & w_bEff;

    // Group 0 starts from the carry-in so every prefix g is directly a group carry-out
    always_comb begin : groupGp
        gp_t acc;
        gp_t bitGp;
        for (int j = 0; j < NG; j++) begin
            acc.g = (j == 0) ? w_c0 : 1'b0;
            acc.p = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                bitGp.g = w_g[j*GROUP+i];
                bitGp.p = w_p[j*GROUP+i];
                acc     = gpCombine(bitGp, acc);
            end
            w_grp[j] = acc;
        end
    end

    prefix_tree_gp #(.N(NG), .CUT_LEVEL(CUT)) u_tree (
        .clk  (clk),
        .i_en (w_adv[0]),
        .i_gp (w_grp),
        .o_gp (w_pre)
    );

    logic [NG-1:0] w_preG;
    logic [NG-1:0] w_unusedPreP;

    always_comb begin
        for (int j = 0; j < NG; j++) begin
            w_preG[j]       = w_pre[j].g;
            w_unusedPreP[j] = w_pre[j].p;
        end
    end

    logic [WIDTH-1:0] w_sP;
    logic [WIDTH-1:0] w_sG;
    logic             w_sAMsb;
    logic             w_sBMsb;
    logic             w_sC0;
    logic [TAG_W-1:0] w_sTag;

    if (STAGES == 1) begin : g_noFirstCut
        assign w_sP    = w_p;
        assign w_sG    = w_g;
        assign w_sAMsb = a[WIDTH-1];
        assign w_sBMsb = w_bEff[WIDTH-1];
        assign w_sC0   = w_c0;
        assign w_sTag  = in_tag;
    end else begin : g_firstCut
        logic [WIDTH-1:0] r_p;
        logic [WIDTH-1:0] r_g;
        logic             r_aMsb;
        logic             r_bMsb;
        logic             r_c0;
        logic [TAG_W-1:0] r_tag;

        // Side data rides alongside the tree's own register row
        always_ff @(posedge clk) begin
            if (w_adv[0]) begin
                r_p    <= w_p;
                r_g    <= w_g;
                r_aMsb <= a[WIDTH-1];
                r_bMsb <= w_bEff[WIDTH-1];
                r_c0   <= w_c0;
                r_tag  <= in_tag;
            end
        end

        assign w_sP    = r_p;
        assign w_sG    = r_g;
        assign w_sAMsb = r_aMsb;
        assign w_sBMsb = r_bMsb;
        assign w_sC0   = r_c0;
        assign w_sTag  = r_tag;
    end

    logic [WIDTH-1:0] w_rP;
    logic [WIDTH-1:0] w_rG;
    logic             w_rAMsb;
    logic             w_rBMsb;
    logic             w_rC0;
    logic [TAG_W-1:0] w_rTag;
    logic [NG-1:0]    w_rPreG;

    if (STAGES == 3) begin : g_treeCut
        logic [WIDTH-1:0] r_p;
        logic [WIDTH-1:0] r_g;
        logic             r_aMsb;
        logic             r_bMsb;
        logic             r_c0;
        logic [TAG_W-1:0] r_tag;
        logic [NG-1:0]    r_preG;

        always_ff @(posedge clk) begin
            if (w_adv[1]) begin
                r_p    <= w_sP;
                r_g    <= w_sG;
                r_aMsb <= w_sAMsb;
                r_bMsb <= w_sBMsb;
                r_c0   <= w_sC0;
                r_tag  <= w_sTag;
                r_preG <= w_preG;
            end
        end

        assign w_rP    = r_p;
        assign w_rG    = r_g;
        assign w_rAMsb = r_aMsb;
        assign w_rBMsb = r_bMsb;
        assign w_rC0   = r_c0;
        assign w_rTag  = r_tag;
        assign w_rPreG = r_preG;
    end else begin : g_noTreeCut
        assign w_rP    = w_sP;
        assign w_rG    = w_sG;
        assign w_rAMsb = w_sAMsb;
        assign w_rBMsb = w_sBMsb;
        assign w_rC0   = w_sC0;
        assign w_rTag  = w_sTag;
        assign w_rPreG = w_preG;
    end

    logic [NG-1:0]    w_grpCin;
    logic [WIDTH-1:0] w_rSum;

    assign w_grpCin = {w_rPreG[NG-2:0], w_rC0};

    always_comb begin : ripple
        logic c;
        w_rSum = '0;
        for (int j = 0; j < NG; j++) begin
            c = w_grpCin[j];
            for (int i = 0; i < GROUP; i++) begin
                w_rSum[j*GROUP+i] = w_rP[j*GROUP+i] ^ c;
                c = w_rG[j*GROUP+i] | (w_rP[j*GROUP+i] & c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
            out_tag <= '0;
        end else if (w_adv[STAGES-1]) begin
            sum     <= w_rSum;
            cout    <= w_rPreG[NG-1];
            ovf     <= (w_rAMsb == w_rBMsb) && (w_rSum[WIDTH-1] != w_rAMsb);
            zero    <= ~|w_rSum;
            out_tag <= w_rTag;
        end
    end

endmodule

// File: doc/pipelined_prefix_adder.md
PIPELINED_PREFIX_ADDER -- requirements
Module: pipelined_prefix_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand width; SHALL be a power of two, 4..64.
REQ-002 Parameter GROUP, default 4, bits per group-level generate/propagate cell; SHALL divide WIDTH, and WIDTH/GROUP SHALL be a power of two, at least 2.
REQ-003 Parameter STAGES, default 2, register stages (1, 2 or 3); equals latency in cycles.
REQ-004 Parameter TAG_W, default 4, width of the pass-through transaction tag.
REQ-005 Ports: clk, input, 1, rising-edge clock; rst, input, 1, synchronous active-high reset.
REQ-006 Ports: in_valid, input, 1, operand beat valid; in_ready, output, 1, beat accepted when in_valid and in_ready are both high.
REQ-007 Ports: a, input, WIDTH, operand A; b, input, WIDTH, operand B; cin, input, 1, carry-in; sub, input, 1, 1 = A minus B.
REQ-008 Ports: in_tag, input, TAG_W, transaction tag.
REQ-009 Ports: out_valid, output, 1, result valid; out_ready, input, 1, consumer accepts the result.
REQ-010 Ports: sum, output, WIDTH, result; cout, output, 1, carry-out; ovf, output, 1, signed overflow; zero, output, 1, sum is zero; out_tag, output, TAG_W, tag of the result.

Function
REQ-011 Effective operands: sub=0 uses B=b and C0=cin; sub=1 uses B=~b and C0=1, with cin ignored.
REQ-012 sum SHALL equal (a + B + C0) mod 2^WIDTH; cout SHALL be carry out of bit WIDTH-1; ovf SHALL be (a[MSB]==B[MSB]) && (sum[MSB]!=a[MSB]); zero SHALL be (sum==0).
REQ-013 Carry computation: per-bit g/p, then group g/p per GROUP bits, then a log2(WIDTH/GROUP)-level parallel-prefix tree over groups, then intra-group ripple.
REQ-014 Register placement, STAGES=1: output register only.
REQ-015 Register placement, STAGES=2: after the group g/p and first half of tree levels (rounded down), plus the output register.
REQ-016 Register placement, STAGES=3: after group g/p, after the full tree, and at the output.
REQ-017 Each stage holds a valid bit; tag and operands needed downstream (a[MSB], B[MSB], per-bit p) travel with data.
REQ-018 Stage k advances when it is empty or stage k+1 advances; the final stage advances when out_valid=0 or out_ready=1.
REQ-019 in_ready SHALL equal (stage 0 empty) OR (stage 0 advances); bubbles SHALL collapse; no combinational path from in_valid to in_ready.
REQ-020 Throughput: one result per cycle while out_ready=1; latency from acceptance to out_valid is exactly STAGES cycles with no stall.
REQ-021 While out_valid=1 and out_ready=0, sum/cout/ovf/zero/out_tag SHALL hold stable.
REQ-022 Results SHALL emerge in acceptance order, none dropped or duplicated.
REQ-023 Simultaneous accept and output on a full pipeline SHALL sustain full throughput.
REQ-024 Wrap-around: all-ones + 1 SHALL give sum=0, cout=1, zero=1.

Reset
REQ-025 rst high at a clock edge SHALL clear all stage valid bits; out_valid=0, sum=0, cout=0, ovf=0, zero=0, out_tag=0.
REQ-026 During rst, in_ready SHALL be 0; the first cycle after rst deasserts, in_ready SHALL be 1.
REQ-027 Reset mid-operation SHALL discard all in-flight beats; none appear after reset.

Structure
REQ-028 Shared package adder_pkg SHALL hold the g/p pair typedef, default parameter constants, and the STAGES legality check.
REQ-029 The prefix tree SHALL be one sub-module, prefix_tree_gp, recursive over group count and parametrised on an optional mid-tree register cut.
REQ-030 No vendor primitives; the `+` operator SHALL NOT compute sum.

Verification
REQ-031 WIDTH=32, STAGES=2: a=0x7FFFFFFF, b=1, sub=0, cin=0 -> after 2 cycles sum=0x80000000, cout=0, ovf=1, zero=0.
REQ-032 a=0xFFFFFFFF, b=0, cin=1, tag=5 -> sum=0, cout=1, ovf=0, zero=1, out_tag=5.
REQ-033 sub=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0; sub=1, a=0x80000000, b=1 -> sum=0x7FFFFFFF, ovf=1.
REQ-034 Stream 8 back-to-back beats with tags 0..7, out_ready low cycles 3-6 -> outputs held stable, tags emerge 0..7 in order, in_ready low only while all stages are full.
REQ-035 Assert rst with 2 beats in flight -> out_valid=0 next cycle, neither beat ever appears.
REQ-036 Random 10k beats for STAGES in {1,2,3} and WIDTH in {8,32,64}, random backpressure -> all match the reference model.
